// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver that turns the serial line into a byte plus a valid or framing-error strobe.
module uart_byte_rx #(
  parameter int clk_mhz  = 50,
  parameter int baud_khz = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int BIT  = 1000 * clk_mhz / baud_khz;
  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(BIT);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nx;
  logic [1:0] sync;
  logic line_s, data_pre, fall, sample;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  assign line_s = sync[1];
  assign fall   = !line_s && data_pre;
  assign sample = cnt == '0;
  assign busy   = state != IDLE;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:  state_nx = fall ? START : IDLE;
      START: state_nx = sample ? (line_s ? IDLE : DATA) : START;
      DATA:  state_nx = (sample && idx == 3'd7) ? STOP : DATA;
      STOP:  state_nx = sample ? IDLE : STOP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  // Datapath: the counter reloads at every sample point, so edges mid-frame never resync it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      data_pre  <= 1'b1;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      rx_byte   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], data};
      data_pre  <= line_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        cnt <= fall ? HALF_M1 : '0;
        idx <= '0;
      end else begin
        cnt <= sample ? BIT_M1 : cnt - 1'b1;
      end
      if (state == DATA && sample) begin
        sh  <= {line_s, sh[7:1]};
        idx <= idx + 3'd1;
      end
      if (state == STOP && sample) begin
        if (line_s) rx_byte <= sh;
        rx_valid  <= line_s;
        frame_err <= !line_s;
      end
    end
  end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: scoreboard bench for the UART receiver at default rates (500 cycles per bit).
module tb_uart_byte_rx;
  logic clk = 1'b0, rst = 1'b1, data = 1'b1;
  logic [7:0] rx_byte;
  logic rx_valid, frame_err, busy;
  int n_chk = 0, n_fail = 0;
  int vcount = 0, fcount = 0, bcount = 0;
  logic prev_v = 1'b0, prev_f = 1'b0;
  time t_valid = 0, t_prev_valid = 0, t0;
  logic [7:0] q[$];

  uart_byte_rx dut (
    .clk(clk), .rst(rst), .data(data), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (busy) bcount++;
    if (rx_valid) begin
      vcount++;
      t_prev_valid = t_valid;
      t_valid = $time;
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("byte", rx_byte, q.pop_front());
    end
    if (frame_err) fcount++;
    if (rx_valid && frame_err) chk("strobe_exclusive", 1, 0);
    if ((rx_valid && prev_v) || (frame_err && prev_f)) chk("strobe_width", 1, 0);
    prev_v = rx_valid;
    prev_f = frame_err;
  end

  task automatic send(input logic [7:0] b, input logic stop, input int len, input bit push);
    data = 1'b0;
    t0 = $time;
    repeat (len) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      data = b[i];
      repeat (len) @(negedge clk);
    end
    if (push) q.push_back(b);
    data = stop;
    repeat (len) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2000) @(negedge clk);
    chk("idle_valid", rx_valid, 0);
    chk("idle_ferr", frame_err, 0);
    chk("idle_busy", busy, 0);
    chk("idle_byte", rx_byte, 8'h00);
    chk("idle_vcount", vcount, 0);

    send(8'hA5, 1'b1, 500, 1'b1);
    chk("a5_latency", 32'((t_valid - t0) / 10), 4753);
    chk("a5_byte", rx_byte, 8'hA5);
    chk("a5_vcount", vcount, 1);
    repeat (100) @(negedge clk);

    send(8'h3C, 1'b1, 500, 1'b1);
    send(8'hFF, 1'b1, 500, 1'b1);
    chk("b2b_spacing", 32'((t_valid - t_prev_valid) / 10), 5000);
    chk("b2b_vcount", vcount, 3);
    chk("b2b_byte", rx_byte, 8'hFF);
    repeat (100) @(negedge clk);

    bcount = 0;
    data = 1'b0;
    repeat (100) @(negedge clk);
    data = 1'b1;
    repeat (400) @(negedge clk);
    chk("glitch_busy_cycles", bcount, 250);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_vcount", vcount, 3);
    chk("glitch_fcount", fcount, 0);

    send(8'h55, 1'b0, 500, 1'b0);
    repeat (3000) @(negedge clk);
    chk("ferr_count", fcount, 1);
    chk("ferr_byte_held", rx_byte, 8'hFF);
    chk("break_no_retrigger", busy, 0);
    chk("ferr_vcount", vcount, 3);
    data = 1'b1;
    repeat (1000) @(negedge clk);

    data = 1'b0;
    repeat (500) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      data = i == 0;
      repeat (500) @(negedge clk);
    end
    data = 1'b0;
    repeat (250) @(negedge clk);
    rst = 1'b1;
    data = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_byte", rx_byte, 8'h00);
    chk("rst_busy", busy, 0);
    repeat (5000) @(negedge clk);
    chk("abort_vcount", vcount, 3);
    chk("abort_fcount", fcount, 1);
    send(8'h0F, 1'b1, 500, 1'b1);
    chk("after_rst_byte", rx_byte, 8'h0F);
    repeat (100) @(negedge clk);

    send(8'hC3, 1'b1, 520, 1'b1);
    repeat (100) @(negedge clk);
    chk("slow_byte", rx_byte, 8'hC3);
    chk("final_vcount", vcount, 5);
    chk("final_fcount", fcount, 1);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- 8N1 UART receiver. Turns the asynchronous serial line into a byte plus a one-cycle valid strobe.
- Directly upstream of the PWM generator: each received byte becomes a new duty setting (the duty-load logic itself is outside this block).
- Single clock domain; the serial input is synchronised internally.

Parameters:
- clk_mhz, 50, system clock frequency in MHz.
- baud_khz, 100, line rate in kbaud.
- BIT (localparam) = 1000*clk_mhz/baud_khz = 500 cycles per bit at defaults; counter width $clog2(BIT).
- HALF (localparam) = BIT/2 = 250 at defaults.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- data  input  1  raw asynchronous serial line, idle high.
- rx_byte  output  8  last received byte, LSB first on the line; holds until the next valid byte.
- rx_valid  output  1  one-cycle pulse when rx_byte updates.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low; rx_byte is not updated.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Synchroniser: two flops on data, reset to 1, giving line_s.
- Edge history: data_pre holds the previous line_s, reset to 1.
- Falling edge is detected in cycle E, where line_s==0 and data_pre==1. Latency from a raw pin change to E is 2 cycles.
- Reset (synchronous, rst=1 at a posedge): state=IDLE, counter=0, bit index=0, rx_byte=8'h00, rx_valid=0, frame_err=0, busy=0, synchroniser flops=1. Reset mid-frame abandons the frame with no strobe.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on a falling edge in cycle E, go to START and load the counter so the first sample lands at E+HALF.
- Sample points are at E + HALF + k*BIT, with k=0 for the start bit, k=1..8 for data bits d0..d7, and k=9 for the stop bit.
- START, at sample k=0:
  - line_s==1 is a false start: return to IDLE with no strobe.
  - Otherwise go to DATA with bit index 0.
- DATA: at each sample, shift line_s into the shift register MSB, shifting right, so d0 ends up in bit 0. After index 7, go to STOP.
- STOP, at sample k=9:
  - line_s==1: rx_byte <= shift register, rx_valid=1 in the next cycle (E+HALF+9*BIT+1).
  - line_s==0: frame_err=1 in that same cycle.
  - Either way, return to IDLE.
- New frame detection: a new frame needs a fresh 1→0 edge. A line held low (break) after a framing error never retriggers the receiver.
- Strobes: rx_valid and frame_err are mutually exclusive and never high for more than 1 cycle.
- Counter: down-counter, reloaded to BIT-1 at each sample point. There is no wrap into undefined values; all states are reachable only via the transitions above. Undefined state encodings go to IDLE.
- Edges mid-frame: edges on line_s during START/DATA/STOP are ignored (no resync). Timing tolerance comes from mid-bit sampling only.
- busy rises in the cycle after E and falls in the cycle rx_valid or frame_err asserts, or after a false start.
- Back-to-back frames: a start edge arriving in the same cycle as the strobe cycle is accepted, because IDLE is re-entered at the strobe cycle and data_pre tracking is continuous.

Test Plan:
- Reset then idle line high for 2000 cycles → rx_valid=0, frame_err=0, busy=0, rx_byte=8'h00.
- Send 8'hA5, 500 cycles/bit, stop=1 → a single rx_valid pulse at E+4751; rx_byte=8'hA5.
- Send 8'h3C then 8'hFF back-to-back with zero idle bits → two rx_valid pulses 5000 cycles apart, with bytes 3C then FF.
- Drive a low glitch of 100 cycles on the line → false start: busy pulses about 250 cycles, no rx_valid, no frame_err, returns to IDLE.
- Send 8'h55 with stop bit forced low, then hold the line low for 3000 cycles → one frame_err pulse, rx_byte unchanged; no retrigger until the line goes high then low again.
- Assert rst at data bit 4 of 8'h81, release, then send 8'h0F → no strobe for the aborted frame; rx_byte=8'h0F after the second frame.
- Send 8'hC3 with every bit period stretched to 520 cycles (4% slow) → rx_byte=8'hC3, rx_valid pulses once.
